pic_inta_sequencer: RTL and testbench
=====================================

Name: pic_inta_sequencer

Overview:
- Interrupt scheduler for the 8259 PIC core: it arbitrates unmasked IRR requests by rotating priority, raises INT and runs the two-pulse INTA handshake.
- It sets and clears the ISR, drives the vector byte, and executes AEOI, EOI and rotation commands.
- It sits between the IRR/IMR registers and the data-bus buffer and takes decoded ICW/OCW fields from the control logic.
- Fully synchronous, single clock.

Parameters:
NUM_IRQ, 8, number of request levels (fixed at 8; level index width is 3)
RESET_LOWEST, 3'd7, lowest-priority level after reset (IR0 highest)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
irr  in  8  pending requests (already edge/level qualified)
imr  in  8  interrupt mask (1 = masked)
vec_base  in  5  ICW2[7:3]
aeoi  in  1  ICW4 auto-EOI enable
rotate_aeoi  in  1  rotate-on-AEOI mode (OCW2 100/000)
inta_n  in  1  CPU acknowledge, already synchronised to clk
eoi_valid  in  1  one-cycle strobe: OCW2 EOI command
eoi_specific  in  1  1 = specific EOI
eoi_level  in  3  level for a specific EOI
eoi_rotate  in  1  rotate priority on this EOI
int_o  out  1  interrupt request to CPU
isr  out  8  in-service register
irr_clear  out  8  one-hot one-cycle pulse that clears the serviced IRR bit
vector_o  out  8  vector byte
vector_valid  out  1  vector_o is to be driven on the bus
lowest_prio  out  3  current lowest-priority level

Behaviour:
- Reset (async, asserted): int_o=0, isr=0, irr_clear=0, vector_o=0, vector_valid=0, lowest_prio=RESET_LOWEST, state=IDLE, inta_q=1. Reset asserted mid-handshake abandons the cycle.
- Edge detect: inta_q <= inta_n each clock.
  - fall = inta_q & ~inta_n
  - rise = ~inta_q & inta_n
- Priority order: highest level is lowest_prio+1 (mod 8), ascending with wrap.
  - cand = irr & ~imr.
  - req_lvl = first set bit of cand in rotated order.
  - isr_lvl = first set bit of isr in rotated order.
  - Both are combinational.
- Fully nested rule: pend = (cand != 0) && (isr == 0 || rank(req_lvl) < rank(isr_lvl)).
- FSM states: IDLE, ACK1, WAIT2, ACK2.
  - IDLE: int_o <= pend (registered, 1-cycle latency). On fall with int_o=1 -> ACK1.
  - IDLE entry into ACK1: latch lvl=req_lvl; set isr[lvl]; irr_clear=onehot(lvl) for exactly 1 cycle; int_o <= 0.
  - Spurious acknowledge (fall while pend=0 at that cycle): lvl=7; no ISR set; no irr_clear.
  - ACK1: wait for rise -> WAIT2.
  - WAIT2: on fall -> ACK2. vector_o <= {vec_base, lvl}; vector_valid <= 1 in the same registered cycle.
  - ACK2: vector_valid held while inta_n low. On rise: vector_valid <= 0 and return to IDLE.
  - ACK2 exit with aeoi=1 (non-spurious): clear isr[lvl]. If rotate_aeoi=1 also set lowest_prio <= lvl.
  - fall in IDLE while int_o=0: treated as spurious, enters ACK1 with lvl=7.
- EOI (eoi_valid, any state):
  - Target = eoi_level if eoi_specific, else isr_lvl.
  - Clear isr[target]. If eoi_rotate, set lowest_prio <= target.
  - Non-specific EOI with isr=0: no-op, and eoi_rotate is ignored.
  - Specific EOI on a level already clear: only the rotation (if requested) applies.
- Simultaneous events:
  - EOI clear and ACK1 set on the same bit in the same cycle: set wins.
  - EOI rotate and AEOI rotate in the same cycle: the AEOI rotate wins.
- Masking a level after ACK1 does not abort the handshake; the vector still uses the latched lvl.
- irr_clear is never asserted in any other state.

Decomposition:
- Package pic_pkg:
  - state enum (IDLE/ACK1/WAIT2/ACK2)
  - NUM_IRQ and LVL_W=3
  - SPURIOUS_LVL=3'd7
  - function rot_first(vec, lowest) returning level and valid flag
- Sub-module pic_priority_resolver: combinational rotated find-first, instanced twice (cand and isr).

Test Plan:
- Basic acknowledge: irr=8'h04, imr=0, vec_base=5'h08 -> int_o=1 after 1 clk. First INTA: isr=8'h04, irr_clear=8'h04 for one pulse. Second INTA: vector_o=8'h42 with vector_valid high until inta_n rises.
- Nesting: isr=8'h04 in service, irr=8'h09 -> int_o=1 and IR0 is serviced (isr=8'h05). Then non-specific EOI -> isr=8'h04. Then irr=8'h08 alone -> int_o stays 0.
- AEOI with rotate: aeoi=1, rotate_aeoi=1, irr=8'h20 -> after second INTA rises, isr=0 and lowest_prio=5. Then irr=8'h41 -> IR6 is serviced first.
- Specific EOI with rotate: isr=8'h12, eoi_specific=1, eoi_level=4, eoi_rotate=1 -> isr=8'h02, lowest_prio=4.
- Spurious acknowledge: int_o=1 for IR3, then irr drops before the first INTA fall -> isr unchanged, no irr_clear, vector_o={vec_base,3'd7}.
- Reset mid-handshake: rst_n low while in WAIT2 -> all outputs at reset values, lowest_prio=7. After release with irr still pending, int_o reasserts one clock later.

Source files
------------

// File: rtl/pic_pkg.sv
// pic_pkg: shared types, constants and rotated-priority helpers for the 8259 INTA sequencer
package pic_pkg;
  localparam int NUM_IRQ = 8;
  localparam int LVL_W = 3;
  localparam logic [LVL_W-1:0] SPURIOUS_LVL = 3'd7;
  typedef enum logic [1:0] {IDLE, ACK1, WAIT2, ACK2} state_t;
  typedef struct packed {
    logic valid;
    logic [LVL_W-1:0] lvl;
  } first_t;
  // Scans from lowest+1 upward with wrap; walking backwards lets the highest priority hit overwrite
  function automatic first_t rot_first(input logic [NUM_IRQ-1:0] vec, input logic [LVL_W-1:0] lowest);
    first_t r;
    logic [LVL_W-1:0] idx;
    r = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      idx = lowest + LVL_W'(i + 1);
      if (vec[idx]) r = '{valid: 1'b1, lvl: idx};
    end
    return r;
  endfunction
  function automatic logic [LVL_W-1:0] rank(input logic [LVL_W-1:0] lvl, input logic [LVL_W-1:0] lowest);
    return lvl - lowest - 3'd1;
  endfunction
  function automatic logic [NUM_IRQ-1:0] onehot(input logic [LVL_W-1:0] lvl);
    return NUM_IRQ'(1) << lvl;
  endfunction
endpackage

// File: rtl/pic_inta_sequencer_if.sv
// pic_inta_sequencer_if: request, acknowledge, command and vector signals around the sequencer
interface pic_inta_sequencer_if;
  import pic_pkg::*;
  logic [NUM_IRQ-1:0] irr;
  logic [NUM_IRQ-1:0] imr;
  logic [4:0] vec_base;
  logic aeoi;
  logic rotate_aeoi;
  logic inta_n;
  logic eoi_valid;
  logic eoi_specific;
  logic [LVL_W-1:0] eoi_level;
  logic eoi_rotate;
  logic int_o;
  logic [NUM_IRQ-1:0] isr;
  logic [NUM_IRQ-1:0] irr_clear;
  logic [7:0] vector_o;
  logic vector_valid;
  logic [LVL_W-1:0] lowest_prio;
  modport master (
    output irr, imr, vec_base, aeoi, rotate_aeoi, inta_n, eoi_valid, eoi_specific, eoi_level, eoi_rotate,
    input int_o, isr, irr_clear, vector_o, vector_valid, lowest_prio
  );
  modport slave (
    input irr, imr, vec_base, aeoi, rotate_aeoi, inta_n, eoi_valid, eoi_specific, eoi_level, eoi_rotate,
    output int_o, isr, irr_clear, vector_o, vector_valid, lowest_prio
  );
endinterface

// File: rtl/pic_priority_resolver.sv
// pic_priority_resolver: combinational find-first over a request vector in rotated priority order
module pic_priority_resolver import pic_pkg::*; (
  input  logic [NUM_IRQ-1:0] vec,
  input  logic [LVL_W-1:0]   lowest,
  output logic               valid,
  output logic [LVL_W-1:0]   lvl
);
  first_t f;
  assign f = rot_first(vec, lowest);
  assign valid = f.valid;
  assign lvl = f.lvl;
endmodule

// File: rtl/pic_inta_sequencer.sv
// pic_inta_sequencer: rotating-priority arbitration, INT generation and two-pulse INTA handshake
module pic_inta_sequencer import pic_pkg::*; #(
  parameter logic [LVL_W-1:0] RESET_LOWEST = 3'd7
) (
  input logic clk,
  input logic rst_n,
  pic_inta_sequencer_if.slave bus
);
  state_t state, state_d;
  logic inta_q, spur, spur_d, int_r, int_d, vec_v, vec_v_d;
  logic [LVL_W-1:0] lvl, lvl_d, lowest, lowest_d, req_lvl, isr_lvl, eoi_tgt;
  logic [NUM_IRQ-1:0] isr, isr_d, irr_clr, irr_clr_d, cand;
  logic [7:0] vec, vec_d;
  logic req_v, isr_v, fall, rise, pend, ack, take, aeoi_done, eoi_hit;
  assign cand = bus.irr & ~bus.imr;
  pic_priority_resolver u_req (.vec(cand), .lowest(lowest), .valid(req_v), .lvl(req_lvl));
  pic_priority_resolver u_isr (.vec(isr), .lowest(lowest), .valid(isr_v), .lvl(isr_lvl));
  assign fall = inta_q & ~bus.inta_n;
  assign rise = ~inta_q & bus.inta_n;
  assign pend = req_v && (!isr_v || rank(req_lvl, lowest) < rank(isr_lvl, lowest));
  assign ack = (state == IDLE) && fall;
  // Only an acknowledge that follows an asserted INT with a still-winning request is genuine
  assign take = ack && int_r && pend;
  assign aeoi_done = (state == ACK2) && rise && bus.aeoi && !spur;
  assign eoi_hit = bus.eoi_valid && (bus.eoi_specific || isr_v);
  assign eoi_tgt = bus.eoi_specific ? bus.eoi_level : isr_lvl;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      inta_q <= 1'b1;
      lvl <= '0;
      spur <= 1'b0;
      int_r <= 1'b0;
      isr <= '0;
      irr_clr <= '0;
      vec <= '0;
      vec_v <= 1'b0;
      lowest <= RESET_LOWEST;
    end else begin
      state <= state_d;
      inta_q <= bus.inta_n;
      lvl <= lvl_d;
      spur <= spur_d;
      int_r <= int_d;
      isr <= isr_d;
      irr_clr <= irr_clr_d;
      vec <= vec_d;
      vec_v <= vec_v_d;
      lowest <= lowest_d;
    end
  end
  always_comb begin
    state_d = ack ? ACK1 :
              (state == ACK1 && rise) ? WAIT2 :
              (state == WAIT2 && fall) ? ACK2 :
              (state == ACK2 && rise) ? IDLE : state;
  end
  // Set from the acknowledge is OR-ed in last so it beats a same-cycle EOI clear
  always_comb begin
    lvl_d = ack ? (take ? req_lvl : SPURIOUS_LVL) : lvl;
    spur_d = ack ? !take : spur;
    int_d = (state == IDLE) && !fall && pend;
    irr_clr_d = take ? onehot(req_lvl) : '0;
    isr_d = (isr & ~(eoi_hit ? onehot(eoi_tgt) : '0) & ~(aeoi_done ? onehot(lvl) : '0)) | irr_clr_d;
    vec_d = (state == WAIT2 && fall) ? {bus.vec_base, lvl} : vec;
    vec_v_d = (state == WAIT2 && fall) ? 1'b1 : (state == ACK2 && rise) ? 1'b0 : vec_v;
    lowest_d = (aeoi_done && bus.rotate_aeoi) ? lvl : (eoi_hit && bus.eoi_rotate) ? eoi_tgt : lowest;
  end
  assign bus.int_o = int_r;
  assign bus.isr = isr;
  assign bus.irr_clear = irr_clr;
  assign bus.vector_o = vec;
  assign bus.vector_valid = vec_v;
  assign bus.lowest_prio = lowest;
endmodule

// File: tb/tb_pic_inta_sequencer.sv
// tb_pic_inta_sequencer: table vectors, directed corner sequences and a randomized run against a behavioural model
module tb_pic_inta_sequencer;
  logic clk, rst_n;
  int cmp, errs;
  pic_inta_sequencer_if bus ();
  pic_inta_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] irr;
    logic [7:0] imr;
    logic [4:0] vb;
    logic       e_int;
    logic [2:0] e_lvl;
  } vec_t;
  vec_t tbl[7];
  // Behavioural reference: priority by integer scan, handshake tracked as a count of INTA edges
  int m_ph;
  logic m_prev, m_spur, m_int, m_vv;
  logic [2:0] m_lvl, m_low;
  logic [7:0] m_isr, m_clr, m_vec;
  function automatic int first(logic [7:0] v, logic [2:0] low);
    for (int k = 1; k <= 8; k++) begin
      int l;
      l = (int'(low) + k) % 8;
      if (v[l]) return l;
    end
    return -1;
  endfunction
  function automatic int rk(int l, logic [2:0] low);
    return (l - int'(low) + 8 + 7) % 8;
  endfunction
  always @(posedge clk or negedge rst_n) begin : mdl
    int rl, il, tgt;
    logic fall, rise, pend;
    logic [7:0] nisr;
    logic [2:0] nlow;
    if (!rst_n) begin
      m_ph <= 0; m_prev <= 1'b1; m_lvl <= 3'd0; m_spur <= 1'b0; m_int <= 1'b0;
      m_isr <= 8'h00; m_clr <= 8'h00; m_vec <= 8'h00; m_vv <= 1'b0; m_low <= 3'd7;
    end else begin
      fall = m_prev && !bus.inta_n;
      rise = !m_prev && bus.inta_n;
      rl = first(bus.irr & ~bus.imr, m_low);
      il = first(m_isr, m_low);
      pend = (rl >= 0) && (il < 0 || rk(rl, m_low) < rk(il, m_low));
      nisr = m_isr;
      nlow = m_low;
      if (bus.eoi_valid) begin
        tgt = bus.eoi_specific ? int'(bus.eoi_level) : il;
        if (tgt >= 0) begin
          nisr[tgt] = 1'b0;
          if (bus.eoi_rotate) nlow = 3'(tgt);
        end
      end
      m_prev <= bus.inta_n;
      m_clr <= 8'h00;
      m_int <= (m_ph == 0 && !fall) ? pend : 1'b0;
      case (m_ph)
        0: if (fall) begin
          m_ph <= 1;
          if (m_int && pend) begin
            m_lvl <= 3'(rl); m_spur <= 1'b0; nisr[rl] = 1'b1; m_clr <= 8'(1) << rl;
          end else begin
            m_lvl <= 3'd7; m_spur <= 1'b1;
          end
        end
        1: if (rise) m_ph <= 2;
        2: if (fall) begin m_ph <= 3; m_vec <= {bus.vec_base, m_lvl}; m_vv <= 1'b1; end
        default: if (rise) begin
          m_ph <= 0; m_vv <= 1'b0;
          if (bus.aeoi && !m_spur) begin
            nisr[m_lvl] = 1'b0;
            if (bus.rotate_aeoi) nlow = m_lvl;
          end
        end
      endcase
      m_isr <= nisr;
      m_low <= nlow;
    end
  end
  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    bus.irr = 8'h00; bus.imr = 8'h00; bus.vec_base = 5'h08; bus.aeoi = 1'b0; bus.rotate_aeoi = 1'b0;
    bus.inta_n = 1'b1; bus.eoi_valid = 1'b0; bus.eoi_specific = 1'b0; bus.eoi_level = 3'd0; bus.eoi_rotate = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, " int_o"}, bus.int_o, 0);
    chk({nm, " isr"}, bus.isr, 0);
    chk({nm, " irr_clear"}, bus.irr_clear, 0);
    chk({nm, " vector_o"}, bus.vector_o, 0);
    chk({nm, " vector_valid"}, bus.vector_valid, 0);
    chk({nm, " lowest"}, bus.lowest_prio, 7);
  endtask
  task automatic ack_cycle(input string nm, input logic [7:0] e_isr, input logic [7:0] e_clr, input logic [7:0] e_vec);
    bus.inta_n = 1'b0;
    tick();
    chk({nm, " isr@ack1"}, bus.isr, e_isr);
    chk({nm, " irr_clear"}, bus.irr_clear, e_clr);
    chk({nm, " int_o@ack1"}, bus.int_o, 0);
    bus.irr = bus.irr & ~e_clr;
    tick();
    chk({nm, " irr_clear end"}, bus.irr_clear, 0);
    bus.inta_n = 1'b1;
    tick();
    bus.inta_n = 1'b0;
    tick();
    chk({nm, " vector"}, bus.vector_o, e_vec);
    chk({nm, " vv on"}, bus.vector_valid, 1);
    tick();
    chk({nm, " vv held"}, bus.vector_valid, 1);
    bus.inta_n = 1'b1;
    tick();
    chk({nm, " vv off"}, bus.vector_valid, 0);
  endtask
  initial begin
    cmp = 0;
    errs = 0;
    tbl[0] = '{8'h01, 8'h00, 5'h00, 1'b1, 3'd0};
    tbl[1] = '{8'h80, 8'h00, 5'h1f, 1'b1, 3'd7};
    tbl[2] = '{8'hf0, 8'h10, 5'h0a, 1'b1, 3'd5};
    tbl[3] = '{8'hff, 8'hff, 5'h01, 1'b0, 3'd0};
    tbl[4] = '{8'h0c, 8'h04, 5'h11, 1'b1, 3'd3};
    tbl[5] = '{8'h00, 8'h00, 5'h02, 1'b0, 3'd0};
    tbl[6] = '{8'ha0, 8'h20, 5'h03, 1'b1, 3'd7};
    rst_n = 1'b0;
    do_reset();
    chk_reset("reset");
    for (int i = 0; i < 7; i++) begin
      logic [7:0] oh;
      do_reset();
      bus.irr = tbl[i].irr; bus.imr = tbl[i].imr; bus.vec_base = tbl[i].vb;
      tick();
      chk($sformatf("tbl%0d int_o", i), bus.int_o, tbl[i].e_int);
      oh = 8'(1) << tbl[i].e_lvl;
      if (tbl[i].e_int) ack_cycle($sformatf("tbl%0d", i), oh, oh, {tbl[i].vb, tbl[i].e_lvl});
    end
    // basic acknowledge
    do_reset();
    bus.irr = 8'h04;
    tick();
    chk("basic int_o", bus.int_o, 1);
    ack_cycle("basic", 8'h04, 8'h04, 8'h42);
    chk("basic isr kept", bus.isr, 8'h04);
    // nesting and non-specific EOI
    bus.irr = 8'h09;
    tick();
    chk("nest int_o", bus.int_o, 1);
    ack_cycle("nest", 8'h05, 8'h01, 8'h40);
    bus.eoi_valid = 1'b1;
    tick();
    bus.eoi_valid = 1'b0;
    chk("nest eoi isr", bus.isr, 8'h04);
    tick(2);
    chk("nest blocked int_o", bus.int_o, 0);
    // AEOI with rotation
    do_reset();
    bus.aeoi = 1'b1; bus.rotate_aeoi = 1'b1; bus.irr = 8'h20;
    tick();
    chk("aeoi int_o", bus.int_o, 1);
    ack_cycle("aeoi", 8'h20, 8'h20, 8'h45);
    chk("aeoi isr", bus.isr, 0);
    chk("aeoi lowest", bus.lowest_prio, 5);
    bus.irr = 8'h41;
    tick();
    chk("rot int_o", bus.int_o, 1);
    ack_cycle("rot", 8'h40, 8'h40, 8'h46);
    chk("rot lowest", bus.lowest_prio, 6);
    // specific EOI with rotation
    do_reset();
    bus.irr = 8'h10;
    tick();
    ack_cycle("seoi a", 8'h10, 8'h10, 8'h44);
    bus.irr = 8'h02;
    tick();
    ack_cycle("seoi b", 8'h12, 8'h02, 8'h41);
    bus.eoi_valid = 1'b1; bus.eoi_specific = 1'b1; bus.eoi_level = 3'd4; bus.eoi_rotate = 1'b1;
    tick();
    bus.eoi_valid = 1'b0;
    chk("seoi isr", bus.isr, 8'h02);
    chk("seoi lowest", bus.lowest_prio, 4);
    // spurious acknowledge
    do_reset();
    bus.vec_base = 5'h0b; bus.irr = 8'h08;
    tick();
    chk("spur int_o", bus.int_o, 1);
    bus.irr = 8'h00; bus.inta_n = 1'b0;
    tick();
    chk("spur isr", bus.isr, 0);
    chk("spur irr_clear", bus.irr_clear, 0);
    bus.inta_n = 1'b1;
    tick();
    bus.inta_n = 1'b0;
    tick();
    chk("spur vector", bus.vector_o, 8'h5f);
    chk("spur vv", bus.vector_valid, 1);
    bus.inta_n = 1'b1;
    tick();
    chk("spur vv off", bus.vector_valid, 0);
    // reset in WAIT2
    do_reset();
    bus.irr = 8'h04; bus.eoi_rotate = 1'b0;
    tick();
    bus.inta_n = 1'b0;
    tick();
    bus.inta_n = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst int_o", bus.int_o, 1);
    // randomized run against the model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (c % 250 == 0) begin bus.aeoi = 1'($urandom); bus.rotate_aeoi = 1'($urandom); end
      bus.irr = bus.irr & ~m_clr;
      if ($urandom_range(0, 5) == 0) bus.irr = bus.irr | 8'($urandom);
      if ($urandom_range(0, 15) == 0) bus.irr = bus.irr & 8'($urandom);
      if ($urandom_range(0, 31) == 0) bus.imr = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 63) == 0) bus.vec_base = 5'($urandom);
      if ($urandom_range(0, 2) == 0) bus.inta_n = ~bus.inta_n;
      bus.eoi_valid = ($urandom_range(0, 7) == 0);
      bus.eoi_specific = 1'($urandom);
      bus.eoi_level = 3'($urandom);
      bus.eoi_rotate = 1'($urandom);
      tick();
      chk("rnd int_o", bus.int_o, m_int);
      chk("rnd isr", bus.isr, m_isr);
      chk("rnd irr_clear", bus.irr_clear, m_clr);
      chk("rnd vector", bus.vector_o, m_vec);
      chk("rnd vv", bus.vector_valid, m_vv);
      chk("rnd lowest", bus.lowest_prio, m_low);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
